// File: rtl/control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/EXECUTE/MEM_READ/STORE/WRITEBACK/TRAP.
// Decodes instruction into execute selects; state drives data-path strobes.
//
// Ports:
//   clk, reset (async, active-low)
//   instruction, read_memory_valid, write_memory_ready      -- inputs
//   *_write_enable, write_memory_enable                      -- strobes
//   write_*_to_*, use_execute_result_for_read_memory         -- data-path selects
//   execute_*, use_*, *_type, csr_number                     -- execute selects
//   illegal_instruction                                      -- high in TRAP
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        read_memory_valid,
    input  logic        write_memory_ready,
    output logic        write_memory_enable,
    output logic        pc_write_enable,
    output logic        instruction_write_enable,
    output logic        register_file_write_enable,
    output logic        execute_result_write_enable,
    output logic        load_memory_data_write_enable,
    output logic        write_immediate_to_register_file,
    output logic        write_load_memory_to_register_file,
    output logic        write_pc_inc_to_register_file,
    output logic        write_execute_result_to_pc,
    output logic        write_execute_result_to_pc_if_compare_met,
    output logic        use_execute_result_for_read_memory,
    output logic        execute_alu,
    output logic        execute_compare,
    output logic        execute_shift,
    output logic        execute_csr,
    output logic        use_immediate,
    output logic        use_immediate_for_compare,
    output logic        use_pc_for_alu,
    output logic [2:0]  immediate_type,
    output logic [2:0]  alu_type,
    output logic [2:0]  compare_type,
    output logic [2:0]  load_memory_decoder_type,
    output logic [1:0]  shift_type,
    output logic [1:0]  store_memory_encoder_type,
    output logic [1:0]  csr_access_type,
    output logic [11:0] csr_number,
    output logic        illegal_instruction
);

    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR = 3'd3, ALU_XOR = 3'd4;
    localparam logic [1:0] SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2;
    localparam logic [2:0] CMP_LT = 3'b100, CMP_LTU = 3'b110;
    localparam logic [1:0] CSR_NONE = 2'd0;

    typedef enum logic [2:0] {
        FETCH, EXECUTE, MEM_READ, STORE, WRITEBACK, TRAP
    } state_t;

    state_t state, next_state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load;
    logic       is_store, is_op_imm, is_op, is_fence, is_system, legal;
    logic       unused_bits;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign alt       = instruction[30];
    assign is_lui    = opcode == 7'b0110111;
    assign is_auipc  = opcode == 7'b0010111;
    assign is_jal    = opcode == 7'b1101111;
    assign is_jalr   = opcode == 7'b1100111;
    assign is_branch = opcode == 7'b1100011;
    assign is_load   = opcode == 7'b0000011;
    assign is_store  = opcode == 7'b0100011;
    assign is_op_imm = opcode == 7'b0010011;
    assign is_op     = opcode == 7'b0110011;
    assign is_fence  = opcode == 7'b0001111;
    assign is_system = opcode == 7'b1110011;
    // ECALL/EBREAK (funct3 = 0) are treated as illegal: no trap handler exists.
    assign legal = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load
                 | is_store | is_op_imm | is_op | is_fence
                 | (is_system & (funct3 != 3'b000));
    assign unused_bits = ^{instruction[19:15], instruction[11:7]};

    assign csr_number                = instruction[31:20];
    assign load_memory_decoder_type  = funct3;
    assign store_memory_encoder_type = funct3[1:0];

    always_comb begin
        execute_alu               = 1'b0;
        execute_compare           = 1'b0;
        execute_shift             = 1'b0;
        execute_csr               = 1'b0;
        use_immediate             = 1'b0;
        use_immediate_for_compare = 1'b0;
        use_pc_for_alu            = 1'b0;
        immediate_type            = IMM_I;
        alu_type                  = ALU_ADD;
        compare_type              = 3'd0;
        shift_type                = SH_SLL;
        unique case (1'b1)
            is_op_imm, is_op: begin
                use_immediate = is_op_imm;
                unique case (funct3)
                    3'b000: begin
                        execute_alu = 1'b1;
                        alu_type = (is_op && alt) ? ALU_SUB : ALU_ADD;
                    end
                    3'b001: execute_shift = 1'b1;
                    3'b010, 3'b011: begin
                        execute_compare = 1'b1;
                        compare_type = funct3[0] ? CMP_LTU : CMP_LT;
                        use_immediate_for_compare = is_op_imm;
                    end
                    3'b100: begin
                        execute_alu = 1'b1;
                        alu_type = ALU_XOR;
                    end
                    3'b101: begin
                        execute_shift = 1'b1;
                        shift_type = alt ? SH_SRA : SH_SRL;
                    end
                    3'b110: begin
                        execute_alu = 1'b1;
                        alu_type = ALU_OR;
                    end
                    default: begin
                        execute_alu = 1'b1;
                        alu_type = ALU_AND;
                    end
                endcase
            end
            is_lui: immediate_type = IMM_U;
            is_auipc, is_jal, is_branch: begin
                execute_alu    = 1'b1;
                use_immediate  = 1'b1;
                use_pc_for_alu = 1'b1;
                immediate_type = is_auipc ? IMM_U : (is_jal ? IMM_J : IMM_B);
                if (is_branch) compare_type = funct3;
            end
            is_jalr, is_load, is_store: begin
                execute_alu    = 1'b1;
                use_immediate  = 1'b1;
                immediate_type = is_store ? IMM_S : IMM_I;
            end
            is_system: begin
                execute_csr   = funct3 != 3'b000;
                use_immediate = funct3[2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state                                = state;
        write_memory_enable                       = 1'b0;
        pc_write_enable                           = 1'b0;
        instruction_write_enable                  = 1'b0;
        register_file_write_enable                = 1'b0;
        execute_result_write_enable               = 1'b0;
        load_memory_data_write_enable             = 1'b0;
        write_immediate_to_register_file          = 1'b0;
        write_load_memory_to_register_file        = 1'b0;
        write_pc_inc_to_register_file             = 1'b0;
        write_execute_result_to_pc                = 1'b0;
        write_execute_result_to_pc_if_compare_met = 1'b0;
        use_execute_result_for_read_memory        = 1'b0;
        csr_access_type                           = CSR_NONE;
        illegal_instruction                       = 1'b0;
        // Strobes stay quiet while reset is held so an abandoned
        // instruction never writes anything.
        if (reset) begin
            unique case (state)
                FETCH: begin
                    instruction_write_enable = read_memory_valid;
                    if (read_memory_valid) begin
                        if (!legal)      next_state = TRAP;
                        else if (is_lui) next_state = WRITEBACK;
                        else             next_state = EXECUTE;
                    end
                end
                EXECUTE: begin
                    execute_result_write_enable = 1'b1;
                    if (execute_csr) csr_access_type = funct3[1:0];
                    if (is_load)       next_state = MEM_READ;
                    else if (is_store) next_state = STORE;
                    else               next_state = WRITEBACK;
                end
                MEM_READ: begin
                    use_execute_result_for_read_memory = 1'b1;
                    load_memory_data_write_enable = read_memory_valid;
                    if (read_memory_valid) next_state = WRITEBACK;
                end
                STORE: begin
                    write_memory_enable = 1'b1;
                    if (write_memory_ready) begin
                        pc_write_enable = 1'b1;
                        next_state = FETCH;
                    end
                end
                WRITEBACK: begin
                    pc_write_enable = 1'b1;
                    register_file_write_enable = !(is_branch || is_fence);
                    write_immediate_to_register_file = is_lui;
                    write_load_memory_to_register_file = is_load;
                    write_pc_inc_to_register_file = is_jal || is_jalr;
                    write_execute_result_to_pc = is_jal || is_jalr;
                    write_execute_result_to_pc_if_compare_met = is_branch;
                    next_state = FETCH;
                end
                TRAP: illegal_instruction = 1'b1;
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        read_memory_valid, write_memory_ready;
    logic        write_memory_enable, pc_write_enable;
    logic        instruction_write_enable, register_file_write_enable;
    logic        execute_result_write_enable, load_memory_data_write_enable;
    logic        write_immediate_to_register_file;
    logic        write_load_memory_to_register_file;
    logic        write_pc_inc_to_register_file, write_execute_result_to_pc;
    logic        write_execute_result_to_pc_if_compare_met;
    logic        use_execute_result_for_read_memory;
    logic        execute_alu, execute_compare, execute_shift, execute_csr;
    logic        use_immediate, use_immediate_for_compare, use_pc_for_alu;
    logic [2:0]  immediate_type, alu_type, compare_type;
    logic [2:0]  load_memory_decoder_type;
    logic [1:0]  shift_type, store_memory_encoder_type, csr_access_type;
    logic [11:0] csr_number;
    logic        illegal_instruction;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk),
        .reset(reset),
        .instruction(instruction),
        .read_memory_valid(read_memory_valid),
        .write_memory_ready(write_memory_ready),
        .write_memory_enable(write_memory_enable),
        .pc_write_enable(pc_write_enable),
        .instruction_write_enable(instruction_write_enable),
        .register_file_write_enable(register_file_write_enable),
        .execute_result_write_enable(execute_result_write_enable),
        .load_memory_data_write_enable(load_memory_data_write_enable),
        .write_immediate_to_register_file(write_immediate_to_register_file),
        .write_load_memory_to_register_file(write_load_memory_to_register_file),
        .write_pc_inc_to_register_file(write_pc_inc_to_register_file),
        .write_execute_result_to_pc(write_execute_result_to_pc),
        .write_execute_result_to_pc_if_compare_met(write_execute_result_to_pc_if_compare_met),
        .use_execute_result_for_read_memory(use_execute_result_for_read_memory),
        .execute_alu(execute_alu),
        .execute_compare(execute_compare),
        .execute_shift(execute_shift),
        .execute_csr(execute_csr),
        .use_immediate(use_immediate),
        .use_immediate_for_compare(use_immediate_for_compare),
        .use_pc_for_alu(use_pc_for_alu),
        .immediate_type(immediate_type),
        .alu_type(alu_type),
        .compare_type(compare_type),
        .load_memory_decoder_type(load_memory_decoder_type),
        .shift_type(shift_type),
        .store_memory_encoder_type(store_memory_encoder_type),
        .csr_access_type(csr_access_type),
        .csr_number(csr_number),
        .illegal_instruction(illegal_instruction)
    );

    // Strobe bit positions, MSB first.
    localparam logic [12:0] S_WME = 13'h1000, S_PC  = 13'h0800;
    localparam logic [12:0] S_IWE = 13'h0400, S_RF  = 13'h0200;
    localparam logic [12:0] S_EX  = 13'h0100, S_LM  = 13'h0080;
    localparam logic [12:0] S_IMM = 13'h0040, S_LD  = 13'h0020;
    localparam logic [12:0] S_PCI = 13'h0010, S_XPC = 13'h0008;
    localparam logic [12:0] S_CMP = 13'h0004, S_RD  = 13'h0002;
    localparam logic [12:0] S_ILL = 13'h0001;

    typedef struct {
        string       name;
        logic [12:0] s;
        logic [1:0]  csr;
        bit          de;
        logic [17:0] d;
        logic [11:0] csrn;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [17:0] mk(
        input bit ea, input bit ec, input bit es, input bit ecsr,
        input bit ui, input bit uic, input bit upc,
        input logic [2:0] alu, input logic [2:0] cmp,
        input logic [1:0] sh, input logic [2:0] imm);
        return {ea, ec, es, ecsr, ui, uic, upc, alu, cmp, sh, imm};
    endfunction

    task automatic cyc(input string n, input bit v, input bit r,
                       input logic [12:0] s, input logic [1:0] c,
                       input bit de, input logic [17:0] d);
        exp_t e;
        read_memory_valid  = v;
        write_memory_ready = r;
        e.name = n;
        e.s    = s;
        e.csr  = c;
        e.de   = de;
        e.d    = d;
        e.csrn = instruction[31:20];
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string n, input bit v, input bit r,
                      input logic [12:0] s);
        cyc(n, v, r, s, 2'd0, 1'b0, 18'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [12:0] as;
        logic [17:0] ad;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            as = {write_memory_enable, pc_write_enable,
                  instruction_write_enable, register_file_write_enable,
                  execute_result_write_enable, load_memory_data_write_enable,
                  write_immediate_to_register_file,
                  write_load_memory_to_register_file,
                  write_pc_inc_to_register_file, write_execute_result_to_pc,
                  write_execute_result_to_pc_if_compare_met,
                  use_execute_result_for_read_memory, illegal_instruction};
            ad = {execute_alu, execute_compare, execute_shift, execute_csr,
                  use_immediate, use_immediate_for_compare, use_pc_for_alu,
                  alu_type, compare_type, shift_type, immediate_type};
            checks++;
            if (as !== e.s) begin
                errors++;
                $display("FAIL %s strobes got %h want %h", e.name, as, e.s);
            end
            checks++;
            if (csr_access_type !== e.csr) begin
                errors++;
                $display("FAIL %s csr_access got %0d want %0d",
                         e.name, csr_access_type, e.csr);
            end
            if (e.de) begin
                checks++;
                if (ad !== e.d) begin
                    errors++;
                    $display("FAIL %s decode got %h want %h", e.name, ad, e.d);
                end
                checks++;
                if (csr_number !== e.csrn) begin
                    errors++;
                    $display("FAIL %s csr_number got %h want %h",
                             e.name, csr_number, e.csrn);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        instruction = 32'h00500093;
        read_memory_valid = 1'b1;
        write_memory_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        st("reset_hold", 1, 1, 13'h0);
        reset = 1'b1;

        // ADDI x1,x0,5
        st("addi_fetch", 1, 0, S_IWE);
        cyc("addi_exec", 1, 0, S_EX, 2'd0, 1, mk(1,0,0,0,1,0,0,0,0,0,0));
        st("addi_wb", 1, 0, S_PC | S_RF);

        // LW x2,0(x1), data valid after two wait cycles
        instruction = 32'h0000A103;
        st("lw_fetch", 1, 0, S_IWE);
        cyc("lw_exec", 0, 0, S_EX, 2'd0, 1, mk(1,0,0,0,1,0,0,0,0,0,0));
        st("lw_wait1", 0, 0, S_RD);
        st("lw_wait2", 0, 0, S_RD);
        st("lw_valid", 1, 0, S_RD | S_LM);
        st("lw_wb", 1, 0, S_PC | S_RF | S_LD);

        // SW x2,4(x1), ready low for three cycles
        instruction = 32'h0020A223;
        st("sw_fetch", 1, 0, S_IWE);
        cyc("sw_exec", 0, 0, S_EX, 2'd0, 1, mk(1,0,0,0,1,0,0,0,0,0,1));
        st("sw_wait1", 0, 0, S_WME);
        st("sw_wait2", 0, 0, S_WME);
        st("sw_wait3", 0, 0, S_WME);
        st("sw_accept", 0, 1, S_WME | S_PC);
        st("fetch_idle", 0, 1, 13'h0);

        // BEQ x0,x0,8
        instruction = 32'h00000463;
        st("beq_fetch", 1, 0, S_IWE);
        cyc("beq_exec", 0, 0, S_EX, 2'd0, 1, mk(1,0,0,0,1,0,1,0,0,0,2));
        st("beq_wb", 0, 0, S_PC | S_CMP);

        // SUB x3,x1,x2
        instruction = 32'h402081B3;
        st("sub_fetch", 1, 0, S_IWE);
        cyc("sub_exec", 0, 0, S_EX, 2'd0, 1, mk(1,0,0,0,0,0,0,1,0,0,0));
        st("sub_wb", 0, 0, S_PC | S_RF);

        // SRAI x1,x1,3
        instruction = 32'h4030D093;
        st("srai_fetch", 1, 0, S_IWE);
        cyc("srai_exec", 0, 0, S_EX, 2'd0, 1, mk(0,0,1,0,1,0,0,0,0,2,0));
        st("srai_wb", 0, 0, S_PC | S_RF);

        // SLTIU x1,x1,1
        instruction = 32'h0010B093;
        st("sltiu_fetch", 1, 0, S_IWE);
        cyc("sltiu_exec", 0, 0, S_EX, 2'd0, 1, mk(0,1,0,0,1,1,0,0,6,0,0));
        st("sltiu_wb", 0, 0, S_PC | S_RF);

        // CSRRSI x1,0x300,5
        instruction = 32'h3002E0F3;
        st("csr_fetch", 1, 0, S_IWE);
        cyc("csr_exec", 0, 0, S_EX, 2'd2, 1, mk(0,0,0,1,1,0,0,0,0,0,0));
        st("csr_wb", 0, 0, S_PC | S_RF);

        // LUI x1,0x12345: two cycles
        instruction = 32'h123450B7;
        st("lui_fetch", 1, 0, S_IWE);
        st("lui_wb", 0, 0, S_PC | S_RF | S_IMM);

        // JAL x1,8
        instruction = 32'h008000EF;
        st("jal_fetch", 1, 0, S_IWE);
        cyc("jal_exec", 0, 0, S_EX, 2'd0, 1, mk(1,0,0,0,1,0,1,0,0,0,4));
        st("jal_wb", 0, 0, S_PC | S_RF | S_PCI | S_XPC);

        // FENCE: no register write
        instruction = 32'h0FF0000F;
        st("fence_fetch", 1, 0, S_IWE);
        cyc("fence_exec", 0, 0, S_EX, 2'd0, 1, mk(0,0,0,0,0,0,0,0,0,0,0));
        st("fence_wb", 0, 0, S_PC);

        // All-ones instruction traps and stays trapped
        instruction = 32'hFFFFFFFF;
        st("ill_fetch", 1, 0, S_IWE);
        for (int i = 0; i < 10; i++) st("trap_hold", 1, 1, S_ILL);
        reset = 1'b0;
        st("trap_reset", 1, 1, 13'h0);
        reset = 1'b1;

        // ECALL traps
        instruction = 32'h00000073;
        st("ecall_fetch", 1, 0, S_IWE);
        st("ecall_trap", 0, 0, S_ILL);
        reset = 1'b0;
        st("ecall_reset", 0, 0, 13'h0);
        reset = 1'b1;

        // Compressed-looking encoding traps
        instruction = 32'h00000001;
        st("c_fetch", 1, 0, S_IWE);
        st("c_trap", 0, 0, S_ILL);
        reset = 1'b0;
        st("c_reset", 0, 0, 13'h0);
        reset = 1'b1;

        // Reset during MEM_READ abandons the load
        instruction = 32'h0000A103;
        st("lwr_fetch", 1, 0, S_IWE);
        st("lwr_exec", 0, 0, S_EX);
        st("lwr_wait", 0, 0, S_RD);
        reset = 1'b0;
        st("lwr_reset", 1, 1, 13'h0);
        reset = 1'b1;
        st("lwr_post_idle", 0, 0, 13'h0);
        instruction = 32'h00500093;
        st("post_fetch", 1, 0, S_IWE);
        st("post_exec", 0, 0, S_EX);
        st("post_wb", 0, 0, S_PC | S_RF);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001: Parameters: none.
REQ-002: clk  in  1  single clock; all state updates on rising edge.
REQ-003: reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately, released synchronously to clk.
REQ-004: instruction  in  32  latched instruction from the data path.
REQ-005: read_memory_valid  in  1  read data on read_memory_data is valid this cycle.
REQ-006: write_memory_ready  in  1  memory accepts the write this cycle.
REQ-007: write_memory_enable  out  1  store request, held until accepted.
REQ-008: pc_write_enable, instruction_write_enable, register_file_write_enable, execute_result_write_enable, load_memory_data_write_enable  out  1 each  data-path register strobes.
REQ-009: write_immediate_to_register_file, write_load_memory_to_register_file, write_pc_inc_to_register_file, write_execute_result_to_pc, write_execute_result_to_pc_if_compare_met, use_execute_result_for_read_memory  out  1 each  data-path selects.
REQ-010: execute_alu, execute_compare, execute_shift, execute_csr, use_immediate, use_immediate_for_compare, use_pc_for_alu  out  1 each  execute selects.
REQ-011: immediate_type 3, alu_type 3, compare_type 3, load_memory_decoder_type 3, shift_type 2, store_memory_encoder_type 2, csr_access_type 2  out  operation codes in the shared encodings.
REQ-012: csr_number  out  12  instruction[31:20].
REQ-013: illegal_instruction  out  1  high while in TRAP.

Function
REQ-014: FSM states: FETCH, EXECUTE, MEM_READ, STORE, WRITEBACK, TRAP.
REQ-015: All strobes in REQ-007/008 are 0 except in the states below; csr_access_type is "none" outside EXECUTE.
REQ-016: FETCH: read address is PC; instruction_write_enable = read_memory_valid; stay until read_memory_valid = 1, then EXECUTE (LUI: WRITEBACK directly).
REQ-017: EXECUTE lasts exactly 1 cycle with execute_result_write_enable = 1; selects decoded from opcode/funct3/funct7.
REQ-018: OP/OP-IMM: alu or shift path; SLT/SLTU(I) use execute_compare; SRA/SRAI selected by instruction[30]; SUB only for OP with instruction[30] = 1.
REQ-019: AUIPC, JAL, branches: use_pc_for_alu = 1, use_immediate = 1, alu ADD; branches also drive compare_type from funct3 with use_immediate_for_compare = 0.
REQ-020: JALR, loads, stores: rs1 + immediate (I or S type), alu ADD; JALR target bit 0 is not cleared.
REQ-021: SYSTEM with funct3 != 0: execute_csr = 1, csr_access_type from funct3[1:0], use_immediate = funct3[2]; funct3 = 0 (ECALL/EBREAK) -> TRAP.
REQ-022: After EXECUTE: loads -> MEM_READ; stores -> STORE; all others -> WRITEBACK.
REQ-023: MEM_READ: use_execute_result_for_read_memory = 1; load_memory_data_write_enable = read_memory_valid; wait for valid, then WRITEBACK.
REQ-024: STORE: write_memory_enable = 1 until write_memory_ready; in the accept cycle pc_write_enable = 1, then FETCH.
REQ-025: WRITEBACK lasts 1 cycle: pc_write_enable = 1; register_file_write_enable = 1 unless branch or FENCE; source per REQ-026; next state FETCH.
REQ-026: Writeback source: LUI immediate; loads load memory; JAL/JALR pc_inc plus write_execute_result_to_pc; branches write_execute_result_to_pc_if_compare_met; else execute result.
REQ-027: FENCE executes as a no-op: FETCH, EXECUTE, WRITEBACK with register write suppressed.
REQ-028: Unknown opcode or instruction[1:0] != 2'b11 -> TRAP; TRAP is absorbing, all strobes 0, until reset.
REQ-029: Latency with zero wait: LUI 2 cycles; ALU/branch/jump/CSR/store 3; load 4; each wait cycle adds 1.

Reset
REQ-030: Reset asserted: state = FETCH, all outputs 0 except combinational fields decoded from instruction; reset mid-operation abandons the instruction with no register, PC or memory write.
REQ-031: First cycle after release is FETCH with read_memory_valid sampled.

Verification
REQ-032: ADDI x1,x0,5 (0x00500093), valid every cycle -> 3 cycles; WRITEBACK has register_file_write_enable = 1, pc_write_enable = 1.
REQ-033: LW x2,0(x1) (0x0000A103), MEM_READ valid delayed 2 cycles -> load_memory_data_write_enable pulses once; total 6 cycles.
REQ-034: SW x2,4(x1) (0x0020A223), write_memory_ready low 3 cycles -> write_memory_enable high 4 cycles; pc_write_enable only in accept cycle.
REQ-035: BEQ (0x00000463) -> WRITEBACK: write_execute_result_to_pc_if_compare_met = 1, register_file_write_enable = 0.
REQ-036: Instruction 0xFFFFFFFF -> TRAP, illegal_instruction = 1 held for 10 cycles; reset low -> FETCH immediately, illegal_instruction = 0.
REQ-037: Reset low during MEM_READ -> no register_file_write_enable pulse; FETCH after release.
